pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Owns the registered fetch PC for the pipelined WISC core. It replaces the combinational PC_control
//  next-PC logic with a sequential unit that adds:
//   - static-offset B prediction from a 2-bit branch history table (BHT);
//   - branch resolution and redirect from EX;
//   - a stall input and a HLT halt state machine.
//  Sits between fetch (imem address) and EX (flags, condition code).
// PARAMETERS
//  ADDR_W     16  PC / address width in bits
//  OFF_W      9   signed B-offset width; the offset counts half-words
//  BHT_DEPTH  8   BHT entry count; must be a power of 2 and >= 2
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  enable        in   1       1 = fetch advances; 0 = stall (PC holds)
//  halt_f        in   1       fetched instruction is HLT
//  is_b_f        in   1       fetched instruction is B (immediate)
//  imm_f         in   OFF_W   B offset of the fetched instruction
//  ex_valid      in   1       a branch instruction is resolving in EX this cycle
//  ex_is_br      in   1       1 = BR (register target); 0 = B
//  ex_cond       in   3       ccc condition code
//  ex_flags      in   3       {Z,V,N}
//  ex_pc         in   ADDR_W  address of the resolving branch
//  ex_imm        in   OFF_W   B offset of the resolving branch
//  ex_rs         in   ADDR_W  register value used as the BR target
//  ex_pred       in   1       pred_taken_o value that travelled with this branch
//  pc_o          out  ADDR_W  current fetch PC (register)
//  pc_plus2_o    out  ADDR_W  pc_o + 2
//  pred_taken_o  out  1       fetched B is predicted taken
//  flush_o       out  1       mispredict: squash the younger IF/ID stages
//  halted_o      out  1       FSM is in HALT
// BEHAVIOUR
//  Reset (async, while rst_n=0):
//   - pc_o = 0 and halted_o = 0; every BHT counter = 2'b01 (weakly not-taken).
//   - flush_o = 0, since ex_valid is gated by reset.
//  Arithmetic:
//   - all address math is mod 2^ADDR_W; no overflow detection.
//   - imm is sign-extended to ADDR_W, then shifted left by 1.
//  Condition taken (ccc):
//   - 000 !Z; 001 Z; 010 !Z&!N; 011 N;
//   - 100 Z|(!Z&!N); 101 Z|N; 110 V; 111 1.
//  Prediction (comb):
//   - idx = pc_o[log2(BHT_DEPTH):1].
//   - pred_taken_o = is_b_f & BHT[idx][1].
//   - predicted target = pc_o + 2 + (sext(imm_f) << 1).
//   - BR is always predicted not-taken.
//  Resolution (comb, when ex_valid=1):
//   - taken = cond(ex_cond, ex_flags).
//   - target = ex_is_br ? ex_rs : ex_pc + 2 + (sext(ex_imm) << 1).
//   - mispredict = taken != ex_pred.
//   - flush_o = ex_valid & mispredict; it is high in the same cycle only.
//   - redirect address = taken ? target : ex_pc + 2.
//  BHT update (at the clock edge, when ex_valid=1 and ex_is_br=0):
//   - entry ex_pc[log2(BHT_DEPTH):1] increments if taken, else decrements.
//   - counters saturate at 00 and 11.
//   - prediction in the same cycle reads the pre-update value.
//  Next PC, in priority order:
//   1. flush_o -> redirect address (overrides stall and halt).
//   2. HALT state or enable=0 -> hold.
//   3. pred_taken_o -> predicted target.
//   4. otherwise pc_o + 2.
//   Latency: pc_o reflects the new address one clock after the decision.
//  Halt FSM:
//   - RUN -> HALT when halt_f & enable & !flush_o; pc_o holds at the HLT address.
//   - HALT -> RUN only on flush_o, because an older mispredicted branch squashes the HLT.
//   - HALT with flush_o = 0 stays in HALT.
//   - halt_f together with flush_o: the redirect wins and the FSM stays in RUN.
//  Reset mid-operation:
//   - immediately forces the reset values.
//   - any in-flight redirect is lost.
// TESTING
//  1. Reset, then enable=1 with no branches for 4 clocks -> pc_o = 0,2,4,6,8.
//  2. is_b_f=1, imm_f=9'h1FE at pc 0x0010, BHT entry 01 -> pred 0 and pc_o = 0x0012. In EX,
//     taken with ex_pred=0 -> flush_o=1 and the next pc_o = 0x000E.
//  3. Three taken B resolves at ex_pc 0x0004 -> counter 01->10->11->11 (saturates).
//     Fetch at 0x0004 with is_b_f=1 -> pred_taken_o=1.
//  4. BR, ccc=111, ex_rs=0xABCD, ex_pred=0 -> flush_o=1, next pc_o=0xABCD.
//     Repeat with enable=0 -> redirect is still taken.
//  5. halt_f at pc 0x0020 -> halted_o=1 and pc_o holds 0x0020 for 10 clocks.
//     Then ex_valid mispredict with target 0x0100 -> halted_o=0, pc_o=0x0100.
//  6. pc_o=0xFFFE, no branch -> next pc_o wraps to 0x0000. Assert rst_n=0 mid-redirect ->
//     pc_o=0 at once and flush_o=0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - registered fetch PC with 2-bit BHT prediction, EX redirect and HLT halt FSM
`timescale 1ns/1ps
module pc_branch_unit #(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 9,
  parameter int BHT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              halt_f,
  input  logic              is_b_f,
  input  logic [OFF_W-1:0]  imm_f,
  input  logic              ex_valid,
  input  logic              ex_is_br,
  input  logic [2:0]        ex_cond,
  input  logic [2:0]        ex_flags,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [OFF_W-1:0]  ex_imm,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic              ex_pred,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus2_o,
  output logic              pred_taken_o,
  output logic              flush_o,
  output logic              halted_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        bht [BHT_DEPTH];

  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic [ADDR_W-1:0] pred_target;
  logic [ADDR_W-1:0] ex_pc_plus2;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] redirect;
  logic              ex_taken;

  // Half-word offset to byte displacement.
  function automatic logic [ADDR_W-1:0] byte_off(input logic [OFF_W-1:0] imm);
    logic [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-OFF_W){imm[OFF_W-1]}}, imm};
    return ext << 1;
  endfunction

  function automatic logic cond_taken(input logic [2:0] ccc, input logic [2:0] flags);
    logic z, v, n;
    {z, v, n} = flags;
    case (ccc)
      3'b000:  return !z;
      3'b001:  return z;
      3'b010:  return !z && !n;
      3'b011:  return n;
      3'b100:  return z || (!z && !n);
      3'b101:  return z || n;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    pred_idx     = pc[IDX_W:1];
    ex_idx       = ex_pc[IDX_W:1];
    pc_plus2_o   = pc + ADDR_W'(2);
    pred_target  = pc_plus2_o + byte_off(imm_f);
    pred_taken_o = is_b_f & bht[pred_idx][1];

    ex_taken     = cond_taken(ex_cond, ex_flags);
    ex_pc_plus2  = ex_pc + ADDR_W'(2);
    ex_target    = ex_is_br ? ex_rs : ex_pc_plus2 + byte_off(ex_imm);
    redirect     = ex_taken ? ex_target : ex_pc_plus2;
    // EX is treated as empty while reset is asserted.
    flush_o      = rst_n & ex_valid & (ex_taken != ex_pred);
  end

  assign pc_o = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (ex_valid && !ex_is_br) begin
      if (ex_taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      else if (!ex_taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
    end
  end

  // A flush always wins: it squashes any younger HLT and leaves HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halted_o <= 1'b0;
      pc       <= '0;
    end else if (flush_o) begin
      state    <= RUN;
      halted_o <= 1'b0;
      pc       <= redirect;
    end else begin
      case (state)
        RUN: begin
          if (enable) begin
            if (halt_f) begin
              state    <= HALT;
              halted_o <= 1'b1;
            end else if (pred_taken_o) begin
              pc <= pred_target;
            end else begin
              pc <= pc_plus2_o;
            end
          end
        end
        default: begin
          state    <= HALT;
          halted_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - randomized and directed bench for pc_branch_unit against an arithmetic model
`timescale 1ns/1ps
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, halt_f, is_b_f, ex_valid, ex_is_br, ex_pred;
  logic [8:0]  imm_f, ex_imm;
  logic [2:0]  ex_cond, ex_flags;
  logic [15:0] ex_pc, ex_rs;
  logic [15:0] pc_o, pc_plus2_o;
  logic        pred_taken_o, flush_o, halted_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc;
  bit m_halt;
  int m_bht [8];

  pc_branch_unit #(.ADDR_W(16), .OFF_W(9), .BHT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .halt_f(halt_f), .is_b_f(is_b_f),
    .imm_f(imm_f), .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_cond(ex_cond),
    .ex_flags(ex_flags), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_pred(ex_pred),
    .pc_o(pc_o), .pc_plus2_o(pc_plus2_o), .pred_taken_o(pred_taken_o),
    .flush_o(flush_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sext(input int imm);
    return (imm >= 256) ? imm - 512 : imm;
  endfunction

  function automatic bit cond_ok(input int ccc, input int flags);
    bit z, v, n;
    z = flags[2]; v = flags[1]; n = flags[0];
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return z || n;
      6: return v;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_halt = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  task automatic idle();
    enable = 1; halt_f = 0; is_b_f = 0; imm_f = 0;
    ex_valid = 0; ex_is_br = 0; ex_cond = 0; ex_flags = 0;
    ex_pc = 0; ex_imm = 0; ex_rs = 0; ex_pred = 0;
  endtask

  // Entered just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic cycle();
    int  idx, eidx, tgt, ptgt, e_redirect;
    bit  e_pred, taken, e_flush;
    #1;
    idx    = (m_pc >> 1) & 7;
    e_pred = is_b_f && (m_bht[idx] >= 2);
    ptgt   = (m_pc + 2 + 2 * sext(int'(imm_f))) & 16'hFFFF;
    taken  = cond_ok(int'(ex_cond), int'(ex_flags));
    tgt    = ex_is_br ? int'(ex_rs) : ((int'(ex_pc) + 2 + 2 * sext(int'(ex_imm))) & 16'hFFFF);
    e_redirect = taken ? tgt : ((int'(ex_pc) + 2) & 16'hFFFF);
    e_flush = ex_valid && (taken != ex_pred);
    check("pc", pc_o, m_pc);
    check("pc_plus2", pc_plus2_o, (m_pc + 2) & 16'hFFFF);
    check("pred", pred_taken_o, e_pred);
    check("flush", flush_o, e_flush);
    check("halted", halted_o, m_halt);
    @(posedge clk);
    if (ex_valid && !ex_is_br) begin
      eidx = (int'(ex_pc) >> 1) & 7;
      if (taken && m_bht[eidx] < 3) m_bht[eidx]++;
      else if (!taken && m_bht[eidx] > 0) m_bht[eidx]--;
    end
    if (e_flush) begin
      m_pc = e_redirect;
      m_halt = 0;
    end else if (!m_halt && enable) begin
      if (halt_f) m_halt = 1;
      else m_pc = e_pred ? ptgt : (m_pc + 2) & 16'hFFFF;
    end
    @(negedge clk);
  endtask

  task automatic br_jump(input logic [15:0] addr);
    ex_valid = 1; ex_is_br = 1; ex_cond = 3'b111; ex_rs = addr; ex_pred = 0;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    check("reset_pc", pc_o, 0);
    check("reset_flush", flush_o, 0);
    check("reset_halted", halted_o, 0);
    @(negedge clk);
    rst_n = 1;

    // 1: straight-line fetch
    for (int i = 0; i < 4; i++) begin
      check("t1_seq", pc_o, 2 * i);
      cycle();
    end
    check("t1_end", pc_o, 16'h0008);

    // 2: backwards B predicted not-taken, then mispredict flush
    br_jump(16'h0010);
    is_b_f = 1; imm_f = 9'h1FE;
    #1 check("t2_pred", pred_taken_o, 0);
    cycle();
    idle();
    check("t2_pc", pc_o, 16'h0012);
    ex_valid = 1; ex_is_br = 0; ex_cond = 3'b111; ex_pc = 16'h0010; ex_imm = 9'h1FE; ex_pred = 0;
    #1 check("t2_flush", flush_o, 1);
    cycle();
    idle();
    check("t2_redirect", pc_o, 16'h000E);

    // 3: BHT saturation at 0x0004
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1; ex_cond = 3'b111; ex_pc = 16'h0004; ex_imm = 9'h004; ex_pred = 1;
      cycle();
    end
    idle();
    br_jump(16'h0004);
    is_b_f = 1; imm_f = 9'h004;
    #1 check("t3_pred", pred_taken_o, 1);
    cycle();
    idle();
    check("t3_target", pc_o, 16'h000E);

    // 4: BR redirect, also while stalled
    br_jump(16'hABCD);
    check("t4_br", pc_o, 16'hABCD);
    enable = 0;
    br_jump(16'h1234);
    check("t4_br_stall", pc_o, 16'h1234);

    // 5: halt holds, flush releases
    br_jump(16'h0020);
    halt_f = 1;
    cycle();
    idle();
    for (int i = 0; i < 10; i++) cycle();
    check("t5_halted", halted_o, 1);
    check("t5_hold", pc_o, 16'h0020);
    br_jump(16'h0100);
    check("t5_release", halted_o, 0);
    check("t5_pc", pc_o, 16'h0100);
    halt_f = 1;
    ex_valid = 1; ex_is_br = 1; ex_cond = 3'b111; ex_rs = 16'h0200; ex_pred = 0;
    cycle();
    idle();
    check("t5_flush_wins", halted_o, 0);

    // 6: wrap and reset during redirect
    br_jump(16'hFFFE);
    cycle();
    check("t6_wrap", pc_o, 16'h0000);
    ex_valid = 1; ex_is_br = 1; ex_cond = 3'b111; ex_rs = 16'h5555; ex_pred = 0;
    #1 check("t6_pre_flush", flush_o, 1);
    rst_n = 0;
    #1;
    check("t6_rst_pc", pc_o, 0);
    check("t6_rst_flush", flush_o, 0);
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1;
    br_jump(16'h0004);
    is_b_f = 1;
    #1 check("t6_bht_reset", pred_taken_o, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(7) != 0);
      halt_f   = ($urandom_range(31) == 0);
      is_b_f   = $urandom_range(1);
      imm_f    = 9'($urandom);
      ex_valid = ($urandom_range(2) == 0);
      ex_is_br = ($urandom_range(3) == 0);
      ex_cond  = 3'($urandom);
      ex_flags = 3'($urandom);
      ex_pc    = 16'($urandom);
      ex_imm   = 9'($urandom);
      ex_rs    = 16'($urandom);
      ex_pred  = $urandom_range(1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
